// File: rtl/ascon_pack.sv
// Shared definitions for the Ascon permutation engine.
//   type_state : 5 x 64-bit Ascon state; word 0 (x0) is the most significant
//                word, so {x0, x1, x2, x3, x4} reads as a test vector.
//   NR_A/NR_B  : round counts of p^12 and p^6.
//   ROT_A/B    : per-word rotate-right amounts of the linear layer.
//   round_const: 8-bit round constant for a 4-bit round index.
//   ror64      : 64-bit rotate right.
package ascon_pack;

  typedef logic [0:4][63:0] type_state;

  localparam int NR_A = 12;
  localparam int NR_B = 6;

  localparam int unsigned ROT_A [5] = '{19, 61, 1, 10, 7};
  localparam int unsigned ROT_B [5] = '{28, 39, 6, 17, 41};

  // High nibble counts down while the low nibble counts up: i=0 -> 0xF0.
  function automatic logic [7:0] round_const(input logic [3:0] idx);
    return {4'hF - idx, idx};
  endfunction

  function automatic logic [63:0] ror64(input logic [63:0] x, input int unsigned n);
    return (x >> n) | (x << (64 - n));
  endfunction

endpackage

// File: rtl/ascon_round.sv
// One Ascon round, combinational: pC, then pS, then pL.
//   round_idx_i : round index 0..11, selects the round constant
//   state_i     : state entering the round
//   state_o     : state leaving the round
module ascon_round
  import ascon_pack::*;
(
  input  logic [3:0] round_idx_i,
  input  type_state  state_i,
  output type_state  state_o
);

  logic [7:0] rc;
  type_state  pc_state;
  type_state  ps_state;

  assign rc       = round_const(round_idx_i);
  // Constant enters the low byte of x2 only.
  assign pc_state = state_i ^ {64'h0, 64'h0, {56'h0, rc}, 64'h0, 64'h0};

  substitution_layer u_sub (
    .state_i (pc_state),
    .state_o (ps_state)
  );

  linear_layer u_lin (
    .state_i (ps_state),
    .state_o (state_o)
  );

endmodule

// File: rtl/linear_layer.sv
// Ascon linear diffusion layer (pL), combinational.
//   state_i : state after substitution
//   state_o : each word XORed with two rotations of itself
module linear_layer
  import ascon_pack::*;
(
  input  type_state state_i,
  output type_state state_o
);

  for (genvar w = 0; w < 5; w++) begin : g_word
    assign state_o[w] = state_i[w]
                      ^ ror64(state_i[w], ROT_A[w])
                      ^ ror64(state_i[w], ROT_B[w]);
  end

endmodule

// File: rtl/substitution_layer.sv
// Ascon substitution layer (pS), combinational.
//   state_i : state after constant addition
//   state_o : state with the 5-bit S-box applied to every bit column j,
//             where x0[j] is the S-box input MSB.
// Bit-sliced form of the S-box: all 64 columns are evaluated in parallel.
module substitution_layer
  import ascon_pack::*;
(
  input  type_state state_i,
  output type_state state_o
);

  logic [63:0] x0, x1, x2, x3, x4;
  logic [63:0] y0, y1, y2, y3, y4;

  // Input mixing.
  assign x0 = state_i[0] ^ state_i[4];
  assign x1 = state_i[1];
  assign x2 = state_i[2] ^ state_i[1];
  assign x3 = state_i[3];
  assign x4 = state_i[4] ^ state_i[3];

  // Chi-like non-linear step.
  assign y0 = x0 ^ (~x1 & x2);
  assign y1 = x1 ^ (~x2 & x3);
  assign y2 = x2 ^ (~x3 & x4);
  assign y3 = x3 ^ (~x4 & x0);
  assign y4 = x4 ^ (~x0 & x1);

  // Output mixing; the inversion of x2 completes the affine map.
  assign state_o[0] = y0 ^ y4;
  assign state_o[1] = y1 ^ y0;
  assign state_o[2] = ~y2;
  assign state_o[3] = y3 ^ y2;
  assign state_o[4] = y4;

endmodule

// File: rtl/ascon_permutation_engine.sv
// Iterative Ascon permutation (p^12 or p^6), UNROLL rounds per clock.
//   clock_i  : rising-edge clock
//   reset_i  : asynchronous active-high reset
//   start_i  : request a permutation; accepted only while idle
//   rounds_i : 0 = p^12 (rounds 0..11), 1 = p^6 (rounds 6..11); sampled on accept
//   state_i  : permutation input; sampled on accept
//   state_o  : state register
//   busy_o   : high while rounds remain
//   done_o   : one-cycle pulse after the final round is registered
module ascon_permutation_engine
  import ascon_pack::*;
#(
  parameter int UNROLL = 1
) (
  input  logic      clock_i,
  input  logic      reset_i,
  input  logic      start_i,
  input  logic      rounds_i,
  input  type_state state_i,
  output type_state state_o,
  output logic      busy_o,
  output logic      done_o
);

  if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 3 || UNROLL == 6)) begin : g_bad_unroll
    $fatal(1, "ascon_permutation_engine: UNROLL must be 1, 2, 3 or 6");
  end

  typedef enum logic {IDLE, RUN} fsm_e;

  fsm_e       fsm_q;
  type_state  state_q;
  type_state  state_d;
  logic [3:0] round_q;
  logic [3:0] round_d;
  logic       busy_q;
  logic       done_q;

  // Round chain: stage k applies round index round_q + k.
  type_state chain [0:UNROLL];
  assign chain[0] = state_q;

  for (genvar k = 0; k < UNROLL; k++) begin : g_chain
    ascon_round u_round (
      .round_idx_i (round_q + 4'(k)),
      .state_i     (chain[k]),
      .state_o     (chain[k+1])
    );
  end

  assign state_d = chain[UNROLL];
  assign round_d = round_q + 4'(UNROLL);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; the state register is reset too, because
  // state_o is architecturally visible and must read zero after reset.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      round_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (fsm_q)
        IDLE: begin
          if (start_i) begin
            state_q <= state_i;
            round_q <= rounds_i ? 4'(NR_A - NR_B) : 4'd0;
            busy_q  <= 1'b1;
            fsm_q   <= RUN;
          end
        end
        RUN: begin
          state_q <= state_d;
          round_q <= round_d;
          // Equality compare: the counter lands exactly on 12 for every
          // legal UNROLL and both start indices.
          if (round_d == 4'(NR_A)) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
            fsm_q  <= IDLE;
          end
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end

  assign state_o = state_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;

endmodule

// File: tb/tb_ascon_permutation_engine.sv
// Self-checking bench for ascon_permutation_engine: four instances
// (UNROLL = 1, 2, 3, 6) share clock, reset and data inputs and are compared
// against a table-driven S-box reference model of the Ascon permutation.
module tb_ascon_permutation_engine;
  import ascon_pack::*;

  localparam int UN [4] = '{1, 2, 3, 6};

  // Ascon 5-bit S-box, index = {x0,x1,x2,x3,x4} bit column.
  localparam bit [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
  };
  localparam int RA [5] = '{19, 61, 1, 10, 7};
  localparam int RB [5] = '{28, 39, 6, 17, 41};

  logic      clk = 1'b0;
  logic      rst;
  logic      start [4];
  logic      rounds_sel;
  type_state st_in;
  logic      busy [4];
  logic      done [4];
  type_state st_out [4];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ascon_permutation_engine #(.UNROLL(1)) u_dut_u1 (
    .clock_i(clk), .reset_i(rst), .start_i(start[0]), .rounds_i(rounds_sel),
    .state_i(st_in), .state_o(st_out[0]), .busy_o(busy[0]), .done_o(done[0]));
  ascon_permutation_engine #(.UNROLL(2)) u_dut_u2 (
    .clock_i(clk), .reset_i(rst), .start_i(start[1]), .rounds_i(rounds_sel),
    .state_i(st_in), .state_o(st_out[1]), .busy_o(busy[1]), .done_o(done[1]));
  ascon_permutation_engine #(.UNROLL(3)) u_dut_u3 (
    .clock_i(clk), .reset_i(rst), .start_i(start[2]), .rounds_i(rounds_sel),
    .state_i(st_in), .state_o(st_out[2]), .busy_o(busy[2]), .done_o(done[2]));
  ascon_permutation_engine #(.UNROLL(6)) u_dut_u6 (
    .clock_i(clk), .reset_i(rst), .start_i(start[3]), .rounds_i(rounds_sel),
    .state_i(st_in), .state_o(st_out[3]), .busy_o(busy[3]), .done_o(done[3]));

  task automatic check(input string name, input logic [319:0] got, input logic [319:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
    logic [127:0] d;
    d = {x, x} >> n;
    return d[63:0];
  endfunction

  function automatic logic [7:0] model_const(input int i);
    return 8'((15 - i) * 16 + i);
  endfunction

  // Reference permutation: rounds first..11 using the S-box table.
  function automatic type_state model_perm(input type_state s, input bit p6);
    logic [63:0] x [5];
    logic [4:0]  idx;
    logic [4:0]  v;
    type_state   r;
    for (int w = 0; w < 5; w++) x[w] = s[w];
    for (int i = (p6 ? 6 : 0); i < 12; i++) begin
      x[2] = x[2] ^ 64'(model_const(i));
      for (int j = 0; j < 64; j++) begin
        idx = {x[0][j], x[1][j], x[2][j], x[3][j], x[4][j]};
        v   = SBOX[idx];
        x[0][j] = v[4]; x[1][j] = v[3]; x[2][j] = v[2]; x[3][j] = v[1]; x[4][j] = v[0];
      end
      for (int w = 0; w < 5; w++) x[w] = x[w] ^ rotr(x[w], RA[w]) ^ rotr(x[w], RB[w]);
    end
    for (int w = 0; w < 5; w++) r[w] = x[w];
    return r;
  endfunction

  function automatic type_state rand_state();
    type_state r;
    for (int w = 0; w < 5; w++) r[w] = {$urandom, $urandom};
    return r;
  endfunction

  // One permutation on instance k: latency, final state, done pulse width,
  // and (on the UNROLL=1 instance) round-constant / pC probes.
  task automatic run_one(input int k, input bit p6, input type_state s,
                         input type_state exp, input string tag);
    int n;
    int first;
    int lat;
    n     = p6 ? 6 : 12;
    first = p6 ? 6 : 0;
    @(negedge clk);
    st_in = s; rounds_sel = p6; start[k] = 1'b1;
    @(negedge clk);
    start[k] = 1'b0; rounds_sel = ~p6; st_in = rand_state();
    check($sformatf("%s_u%0d_busy_run", tag, UN[k]), busy[k], 1'b1);
    lat = -1;
    for (int c = 0; c <= 40; c++) begin
      if (k == 0 && c == 0) begin
        check($sformatf("%s_rc_first", tag), u_dut_u1.g_chain[0].u_round.rc, model_const(first));
        check($sformatf("%s_pc_x2", tag), u_dut_u1.g_chain[0].u_round.pc_state[2],
              s[2] ^ 64'(model_const(first)));
      end
      if (k == 0 && c == n - 1)
        check($sformatf("%s_rc_last", tag), u_dut_u1.g_chain[0].u_round.rc, model_const(11));
      if (done[k]) begin
        lat = c;
        break;
      end
      @(negedge clk);
    end
    check($sformatf("%s_u%0d_latency", tag, UN[k]), lat, n / UN[k]);
    check($sformatf("%s_u%0d_state", tag, UN[k]), st_out[k], exp);
    check($sformatf("%s_u%0d_busy_done", tag, UN[k]), busy[k], 1'b0);
    @(negedge clk);
    check($sformatf("%s_u%0d_done_width", tag, UN[k]), done[k], 1'b0);
    check($sformatf("%s_u%0d_state_hold", tag, UN[k]), st_out[k], exp);
  endtask

  typedef struct {
    string     name;
    bit        p6;
    type_state in;
    type_state exp;
  } vec_t;

  initial begin
    vec_t      vecs [6];
    type_state golden_in;
    type_state held [4];
    int        accepts, dones, t1, t2, spurious;
    logic      prev_busy;

    rst = 1'b1;
    for (int k = 0; k < 4; k++) start[k] = 1'b0;
    rounds_sel = 1'b0;
    st_in = '0;

    golden_in = {64'h80400c0600000000, 64'h0001020304050607, 64'h08090a0b0c0d0e0f,
                 64'h0001020304050607, 64'h08090a0b0c0d0e0f};

    vecs[0] = '{"golden_p12", 1'b0, golden_in, '0};
    vecs[1] = '{"golden_p6",  1'b1, golden_in, '0};
    vecs[2] = '{"zero_p12",   1'b0, '0, '0};
    vecs[3] = '{"rand_p12",   1'b0, rand_state(), '0};
    vecs[4] = '{"rand_p6",    1'b1, rand_state(), '0};
    vecs[5] = '{"ones_p6",    1'b1, '1, '0};
    for (int v = 0; v < 6; v++) vecs[v].exp = model_perm(vecs[v].in, vecs[v].p6);

    // Reset state.
    repeat (2) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("reset_busy_u%0d", UN[k]), busy[k], 1'b0);
      check($sformatf("reset_done_u%0d", UN[k]), done[k], 1'b0);
      check($sformatf("reset_state_u%0d", UN[k]), st_out[k], '0);
    end
    rst = 1'b0;

    // Vector table across all unroll factors.
    for (int v = 0; v < 6; v++)
      for (int k = 0; k < 4; k++)
        run_one(k, vecs[v].p6, vecs[v].in, vecs[v].exp, vecs[v].name);

    // Handshake: start held high through a run, still high in the done cycle.
    @(negedge clk);
    st_in = golden_in; rounds_sel = 1'b0; start[0] = 1'b1;
    prev_busy = busy[0];
    accepts = 0; dones = 0; t1 = -1; t2 = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (busy[0] && !prev_busy) accepts++;
      prev_busy = busy[0];
      if (done[0]) begin
        dones++;
        if (t1 < 0) t1 = c; else t2 = c;
      end
      if (dones >= 1 && !done[0]) start[0] = 1'b0;
    end
    check("hs_accepts", accepts, 2);
    check("hs_dones", dones, 2);
    check("hs_period", t2 - t1, 13);
    check("hs_state", st_out[0], vecs[0].exp);

    // Idle stability with toggling data inputs.
    held[0] = vecs[0].exp;
    for (int k = 1; k < 4; k++) held[k] = vecs[5].exp;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      st_in = rand_state();
      rounds_sel = ~rounds_sel;
      for (int k = 0; k < 4; k++) begin
        check($sformatf("idle_state_u%0d", UN[k]), st_out[k], held[k]);
        check($sformatf("idle_busy_u%0d", UN[k]), busy[k], 1'b0);
        check($sformatf("idle_done_u%0d", UN[k]), done[k], 1'b0);
      end
    end

    // Reset mid-run: abort in round 5 of p^12 on the UNROLL=1 instance.
    @(negedge clk);
    st_in = golden_in; rounds_sel = 1'b0; start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (5) @(negedge clk);
    check("midrun_busy_before", busy[0], 1'b1);
    rst = 1'b1;
    #1;
    check("midrun_busy", busy[0], 1'b0);
    check("midrun_done", done[0], 1'b0);
    check("midrun_state", st_out[0], '0);
    @(negedge clk);
    rst = 1'b0;
    spurious = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) if (done[k] || busy[k]) spurious++;
    end
    check("midrun_no_done", spurious, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
